// File: rtl/wb_request_queue.sv
// Write-back request FIFO feeding the register-file write-enable decoder.
// Requests are queued in order, retired one per cycle, and forwarded to the read stage.
module wb_request_queue #(
   parameter int unsigned N       = 3,
   parameter int unsigned W       = 32,
   parameter int unsigned DEPTH   = 4,
   parameter bit          ZERO_R0 = 1'b1,
   localparam int unsigned AW     = $clog2(DEPTH),
   localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_addr,
   input  logic [W-1:0]  in_data,
   input  logic          port_busy,
   output logic [N-1:0]  code,
   output logic          enabler,
   output logic [W-1:0]  wr_data,
   input  logic [N-1:0]  fwd_addr,
   output logic          fwd_hit,
   output logic [W-1:0]  fwd_data,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("DEPTH must be a power of two and at least 2");
   end

   logic [N-1:0]  r_addr [DEPTH];
   logic [W-1:0]  r_data [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic          w_empty;
   logic          w_full;
   logic          w_push_hs;
   logic          w_store;
   logic          w_pop;
   logic          w_fwd_block;
   logic          w_fwd_hit;
   logic [W-1:0]  w_fwd_data;
   logic [AW-1:0] w_idx;
   logic [CW-1:0] w_count_next;

   // Occupancy comes only from the counter, so a wrapped full queue is never mistaken for empty.
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));

   assign w_push_hs = in_valid && !w_full && !flush;
   assign w_store   = w_push_hs && !(ZERO_R0 && (in_addr == '0));
   assign w_pop     = !w_empty && !port_busy && !flush;

   always_comb begin
      w_count_next = r_count;
      if (flush) begin
         w_count_next = '0;
      end else begin
         w_count_next = r_count + CW'(w_store) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_count <= w_count_next;
         if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
         end else begin
            if (w_store) begin
               r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + AW'(1);
            end
         end
      end
   end

   // Storage is left unreset; every output that reads it is masked by the occupancy.
   always_ff @(posedge clk) begin
      if (w_store) begin
         r_addr[r_wr_ptr] <= in_addr;
         r_data[r_wr_ptr] <= in_data;
      end
   end

   assign w_fwd_block = ZERO_R0 && (fwd_addr == '0);

   // Walk from head to tail so the youngest matching entry wins.
   always_comb begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = '0;
      w_idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_rd_ptr + AW'(i);
         if ((CW'(i) < r_count) && (r_addr[w_idx] == fwd_addr) && !w_fwd_block) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_data[w_idx];
         end
      end
   end

   assign in_ready = !w_full;
   assign enabler  = w_pop;
   assign code     = w_empty ? '0 : r_addr[r_rd_ptr];
   assign wr_data  = w_empty ? '0 : r_data[r_rd_ptr];
   assign fwd_hit  = w_fwd_hit;
   assign fwd_data = w_fwd_data;
   assign count    = r_count;
   assign empty    = w_empty;
   assign full     = w_full;

   a_count_bound : assert property (@(posedge clk) disable iff (!rst_n) r_count <= CW'(DEPTH));
   a_ptr_gap : assert property (@(posedge clk) disable iff (!rst_n)
      (r_wr_ptr - r_rd_ptr) == AW'(r_count));

endmodule

// File: tb/tb_wb_request_queue.sv
// Bench for wb_request_queue: directed vector table, hand sequences, and random traffic
// checked against a queue-based reference model.
module tb_wb_request_queue;

   localparam int unsigned N       = 3;
   localparam int unsigned W       = 32;
   localparam int unsigned DEPTH   = 4;
   localparam bit          ZERO_R0 = 1'b1;
   localparam int unsigned CW      = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_addr;
   logic [W-1:0]  in_data;
   logic          port_busy;
   logic [N-1:0]  code;
   logic          enabler;
   logic [W-1:0]  wr_data;
   logic [N-1:0]  fwd_addr;
   logic          fwd_hit;
   logic [W-1:0]  fwd_data;
   logic [CW-1:0] count;
   logic          empty;
   logic          full;

   wb_request_queue #(
      .N      (N),
      .W      (W),
      .DEPTH  (DEPTH),
      .ZERO_R0(ZERO_R0)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_addr  (in_addr),
      .in_data  (in_data),
      .port_busy(port_busy),
      .code     (code),
      .enabler  (enabler),
      .wr_data  (wr_data),
      .fwd_addr (fwd_addr),
      .fwd_hit  (fwd_hit),
      .fwd_data (fwd_data),
      .count    (count),
      .empty    (empty),
      .full     (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] addr;
      logic [W-1:0] data;
   } ent_t;

   typedef struct {
      logic         flush;
      logic         valid;
      logic [N-1:0] addr;
      logic [W-1:0] data;
      logic         busy;
      logic [N-1:0] fwd;
      int           e_count;
      logic         e_en;
      logic [N-1:0] e_code;
      logic [W-1:0] e_wd;
      logic         e_hit;
      logic [W-1:0] e_fd;
      logic         e_rdy;
   } vec_t;

   ent_t q[$];
   vec_t tbl[23];
   int   vectors = 0;
   int   miscompares = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic fl, input logic v, input logic [N-1:0] a,
                               input logic [W-1:0] d, input logic b, input logic [N-1:0] f,
                               input int c, input logic en, input logic [N-1:0] cd,
                               input logic [W-1:0] wd, input logic h, input logic [W-1:0] fd,
                               input logic r);
      vec_t t;
      t.flush = fl; t.valid = v; t.addr = a; t.data = d; t.busy = b; t.fwd = f;
      t.e_count = c; t.e_en = en; t.e_code = cd; t.e_wd = wd; t.e_hit = h; t.e_fd = fd;
      t.e_rdy = r;
      return t;
   endfunction

   // Reference: the queue holds exactly the accepted, non-retired requests in arrival order.
   task automatic model_check(input string tag);
      int           sz;
      logic [N-1:0] e_code;
      logic [W-1:0] e_wd;
      logic         e_hit;
      logic [W-1:0] e_fd;
      sz     = q.size();
      e_code = (sz > 0) ? q[0].addr : '0;
      e_wd   = (sz > 0) ? q[0].data : '0;
      e_hit  = 1'b0;
      e_fd   = '0;
      if (!(ZERO_R0 && fwd_addr == 0)) begin
         for (int i = sz - 1; i >= 0; i--) begin
            if (q[i].addr == fwd_addr) begin
               e_hit = 1'b1;
               e_fd  = q[i].data;
               break;
            end
         end
      end
      chk({tag, ".count"},    32'(count),    32'(sz));
      chk({tag, ".empty"},    32'(empty),    32'(sz == 0));
      chk({tag, ".full"},     32'(full),     32'(sz == DEPTH));
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(sz < DEPTH));
      chk({tag, ".enabler"},  32'(enabler),  32'((sz > 0) && !port_busy && !flush));
      chk({tag, ".code"},     32'(code),     32'(e_code));
      chk({tag, ".wr_data"},  wr_data,       e_wd);
      chk({tag, ".fwd_hit"},  32'(fwd_hit),  32'(e_hit));
      chk({tag, ".fwd_data"}, fwd_data,      e_fd);
   endtask

   task automatic advance();
      bit en;
      bit acc;
      en  = (q.size() > 0) && !port_busy && !flush;
      acc = in_valid && (q.size() < DEPTH) && !flush;
      @(posedge clk);
      if (flush) begin
         q.delete();
      end else begin
         if (en) q.delete(0);
         if (acc && !(ZERO_R0 && in_addr == 0)) q.push_back(ent_t'{addr: in_addr, data: in_data});
      end
      #1;
   endtask

   task automatic drive(input logic fl, input logic v, input logic [N-1:0] a,
                        input logic [W-1:0] d, input logic b, input logic [N-1:0] f);
      flush = fl; in_valid = v; in_addr = a; in_data = d; port_busy = b; fwd_addr = f;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
      #3;
      chk("rst.count", 32'(count), 0);
      chk("rst.empty", 32'(empty), 1);
      chk("rst.in_ready", 32'(in_ready), 1);
      chk("rst.enabler", 32'(enabler), 0);
      chk("rst.code", 32'(code), 0);
      chk("rst.fwd_hit", 32'(fwd_hit), 0);
      #5 rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int c = 0; c < 5; c++) begin
         #2;
         chk("idle.empty", 32'(empty), 1);
         chk("idle.in_ready", 32'(in_ready), 1);
         chk("idle.enabler", 32'(enabler), 0);
         chk("idle.code", 32'(code), 0);
         chk("idle.count", 32'(count), 0);
         advance();
      end

      // Columns: flush valid addr data busy fwd | count en code wr_data hit fwd_data ready
      tbl[0]  = mk(0, 1, 5, 32'hDEADBEEF, 0, 5, 0, 0, 0, 0,            0, 0,            1);
      tbl[1]  = mk(0, 0, 0, 0,            0, 5, 1, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1);
      tbl[2]  = mk(0, 0, 0, 0,            0, 5, 0, 0, 0, 0,            0, 0,            1);
      tbl[3]  = mk(0, 1, 1, 32'h101,      1, 1, 0, 0, 0, 0,            0, 0,            1);
      tbl[4]  = mk(0, 1, 2, 32'h102,      1, 1, 1, 0, 1, 32'h101,      1, 32'h101,      1);
      tbl[5]  = mk(0, 1, 3, 32'h103,      1, 1, 2, 0, 1, 32'h101,      1, 32'h101,      1);
      tbl[6]  = mk(0, 1, 4, 32'h104,      1, 1, 3, 0, 1, 32'h101,      1, 32'h101,      1);
      tbl[7]  = mk(0, 1, 5, 32'h105,      1, 1, 4, 0, 1, 32'h101,      1, 32'h101,      0);
      tbl[8]  = mk(0, 0, 0, 0,            0, 1, 4, 1, 1, 32'h101,      1, 32'h101,      0);
      tbl[9]  = mk(0, 0, 0, 0,            0, 1, 3, 1, 2, 32'h102,      0, 0,            1);
      tbl[10] = mk(0, 0, 0, 0,            0, 1, 2, 1, 3, 32'h103,      0, 0,            1);
      tbl[11] = mk(0, 0, 0, 0,            0, 1, 1, 1, 4, 32'h104,      0, 0,            1);
      tbl[12] = mk(0, 0, 0, 0,            0, 1, 0, 0, 0, 0,            0, 0,            1);
      tbl[13] = mk(0, 1, 3, 32'h11,       1, 3, 0, 0, 0, 0,            0, 0,            1);
      tbl[14] = mk(0, 1, 6, 32'h22,       1, 3, 1, 0, 3, 32'h11,       1, 32'h11,       1);
      tbl[15] = mk(0, 1, 3, 32'h33,       1, 6, 2, 0, 3, 32'h11,       1, 32'h22,       1);
      tbl[16] = mk(0, 0, 0, 0,            1, 3, 3, 0, 3, 32'h11,       1, 32'h33,       1);
      tbl[17] = mk(0, 0, 0, 0,            1, 6, 3, 0, 3, 32'h11,       1, 32'h22,       1);
      tbl[18] = mk(0, 0, 0, 0,            1, 7, 3, 0, 3, 32'h11,       0, 0,            1);
      tbl[19] = mk(0, 1, 0, 32'h99,       1, 0, 3, 0, 3, 32'h11,       0, 0,            1);
      tbl[20] = mk(0, 0, 0, 0,            1, 0, 3, 0, 3, 32'h11,       0, 0,            1);
      tbl[21] = mk(1, 1, 2, 32'h77,       0, 3, 3, 0, 3, 32'h11,       1, 32'h33,       1);
      tbl[22] = mk(0, 0, 0, 0,            0, 2, 0, 0, 0, 0,            0, 0,            1);

      for (int r = 0; r < 23; r++) begin
         string tag;
         tag = $sformatf("tbl[%0d]", r);
         drive(tbl[r].flush, tbl[r].valid, tbl[r].addr, tbl[r].data, tbl[r].busy, tbl[r].fwd);
         #2;
         chk({tag, ".count"},    32'(count),    32'(tbl[r].e_count));
         chk({tag, ".enabler"},  32'(enabler),  32'(tbl[r].e_en));
         chk({tag, ".code"},     32'(code),     32'(tbl[r].e_code));
         chk({tag, ".wr_data"},  wr_data,       tbl[r].e_wd);
         chk({tag, ".fwd_hit"},  32'(fwd_hit),  32'(tbl[r].e_hit));
         chk({tag, ".fwd_data"}, fwd_data,      tbl[r].e_fd);
         chk({tag, ".in_ready"}, 32'(in_ready), 32'(tbl[r].e_rdy));
         model_check(tag);
         advance();
      end

      // Streaming at one request per cycle wraps both pointers with occupancy held at one.
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b1, N'((i % 7) + 1), 32'h1000 + 32'(i), 1'b0, N'((i % 7) + 1));
         #2;
         if (i > 0) begin
            chk("stream.count", 32'(count), 1);
            chk("stream.code", 32'(code), 32'(((i - 1) % 7) + 1));
            chk("stream.wr_data", wr_data, 32'h1000 + 32'(i - 1));
         end
         model_check("stream");
         advance();
      end
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
      #2;
      chk("stream.last_code", 32'(code), 3);
      chk("stream.last_en", 32'(enabler), 1);
      model_check("stream_tail");
      advance();
      #2;
      chk("stream.drained", 32'(empty), 1);
      advance();

      for (int c = 0; c < 600; c++) begin
         drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 9) < 7), N'($urandom),
               $urandom, ($urandom_range(0, 9) < 4), N'($urandom));
         #2;
         model_check("rand");
         advance();
      end

      // Two queued entries, then reset asserted between clock edges.
      drive(1'b1, 1'b0, '0, '0, 1'b1, '0);
      advance();
      drive(1'b0, 1'b1, 3'd2, 32'hA2, 1'b1, 3'd2);
      advance();
      drive(1'b0, 1'b1, 3'd4, 32'hA4, 1'b1, 3'd2);
      advance();
      drive(1'b0, 1'b0, '0, '0, 1'b0, 3'd2);
      #1;
      chk("pre_rst.count", 32'(count), 2);
      chk("pre_rst.enabler", 32'(enabler), 1);
      rst_n = 1'b0;
      #1;
      q.delete();
      chk("async_rst.empty", 32'(empty), 1);
      chk("async_rst.enabler", 32'(enabler), 0);
      chk("async_rst.count", 32'(count), 0);
      chk("async_rst.code", 32'(code), 0);
      chk("async_rst.fwd_hit", 32'(fwd_hit), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      #2;
      model_check("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/wb_request_queue.md
Name: wb_request_queue

Overview:
- Register-file write-back buffer sitting directly upstream of the one-hot write-enable decoder.
- Accepts write-back requests (register index + data) from the execute/memory stage via a valid/ready handshake and queues them in order.
- Retires at most one request per cycle by driving the decoder's code/enabler inputs plus the write data.
- Provides a forwarding lookup so the read stage can see queued, not-yet-written values.

Parameters:
- N, 3, register index width; register file has 2**N entries (matches decoder N).
- W, 32, data width.
- DEPTH, 4, queue entries; power of two, >= 2.
- ZERO_R0, 1, when 1 writes to register 0 are accepted on the handshake but discarded (never enqueued).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all queued entries.
- in_valid  in  1  request valid.
- in_ready  out  1  queue can accept; equals !full.
- in_addr  in  N  destination register index.
- in_data  in  W  write data.
- port_busy  in  1  register-file write port unavailable this cycle.
- code  out  N  head register index to decoder; 0 when empty.
- enabler  out  1  decoder enable; a retire occurs on every edge where enabler=1.
- wr_data  out  W  head data; 0 when empty.
- fwd_addr  in  N  read-stage lookup index.
- fwd_hit  out  1  some queued entry targets fwd_addr.
- fwd_data  out  W  data of the youngest matching entry; 0 when no hit.
- count  out  $clog2(DEPTH)+1  number of queued entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rd/wr pointers=0, count=0, empty=1, full=0, in_ready=1.
  - enabler=0, code=0, wr_data=0, fwd_hit=0, fwd_data=0.
  - Storage array is not reset; outputs are masked by the valid state.
  - Asserting reset mid-operation drops all entries immediately; no retire occurs on that edge.
- Push (handshake):
  - push = in_valid && in_ready && !flush.
  - If ZERO_R0=1 and in_addr==0, the handshake completes but nothing is stored and count is unchanged.
  - Otherwise the entry is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Retire:
  - enabler = !empty && !port_busy && !flush (combinational from registered state and inputs).
  - code and wr_data are taken from the head entry.
  - Pop on an edge with enabler=1; rd_ptr increments modulo DEPTH.
- Latency:
  - An entry pushed at edge k is visible at the head (earliest enabler) in cycle k+1 when the queue was empty.
  - There is no same-cycle pass-through from in_* to code.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - When full, in_ready=0 even if a pop happens that cycle; there is no combinational ready-from-pop path.
- Flush:
  - Takes priority over push and pop; next state is count=0 and pointers=0.
  - enabler=0 and in_ready behaves per full during the flush cycle, but no push is accepted.
- Ordering: strict FIFO; multiple entries to the same register all retire in order.
- Forwarding:
  - Combinational compare of fwd_addr against all valid entries.
  - fwd_data is the entry closest to the tail (youngest).
  - An entry retiring this cycle is still counted as a hit.
  - The incoming in_* request is not considered.
  - With ZERO_R0=1, fwd_addr==0 always gives fwd_hit=0.
- Pointer wrap: the full/empty distinction uses count, never pointer equality alone.
- port_busy stalls:
  - The head is held stable (code, wr_data unchanged) while port_busy=1.
  - Pushes continue until full.

Test Plan:
- Reset then idle: release rst_n with in_valid=0 -> empty=1, in_ready=1, enabler=0, code=0, count=0 for 5 cycles.
- Single write: push addr=5, data=0xDEADBEEF, port_busy=0 -> next cycle enabler=1, code=5, wr_data=0xDEADBEEF; the following cycle empty=1, enabler=0.
- Fill and stall: port_busy=1, push addrs 1,2,3,4 -> count=4, full=1, in_ready=0, enabler=0, code=1. Then drop port_busy -> enabler high 4 consecutive cycles with code 1,2,3,4, count reaching 0.
- Wrap plus simultaneous push/pop: stream 10 requests at one per cycle with port_busy=0 -> count stays 1 after the first, codes retire in order, pointers wrap with no loss or duplication.
- Forwarding: port_busy=1, push (addr 3, 0x11), (addr 6, 0x22), (addr 3, 0x33):
  - fwd_addr=3 -> hit, 0x33.
  - fwd_addr=6 -> hit, 0x22.
  - fwd_addr=7 -> hit=0, data=0.
- Zero register, flush, async reset:
  - With ZERO_R0=1, push addr=0 -> in_ready handshake completes, count stays 0.
  - Queue 3 entries then pulse flush with in_valid=1 -> count=0 next cycle, pushed entry not stored.
  - Queue 2 entries, assert rst_n=0 mid-cycle -> empty=1 and enabler=0 immediately, without a clock edge.
